// File: rtl/polaris_bus_arbiter.sv
// Round-robin arbiter sharing one memory port between the fetch and data ports of PolarisCPU.
// Optional watchdog: define POLARIS_ARB_TIMEOUT_EN to abort grants that see no mack_i within TO_CYC cycles.
module polaris_bus_arbiter #(
    parameter int unsigned AW     = 64,
    parameter int unsigned IDW    = 32,
    parameter int unsigned DW     = 64,
    parameter int unsigned TO_CYC = 255
) (
    input  logic           clk_i,
    input  logic           reset_i,
    input  logic [AW-1:0]  iadr_i,
    input  logic           istb_i,
    output logic           iack_o,
    output logic [IDW-1:0] idat_o,
    output logic           ierr_o,
    input  logic [AW-1:0]  dadr_i,
    input  logic           dstb_i,
    input  logic           dwe_i,
    input  logic [1:0]     dsiz_i,
    input  logic [DW-1:0]  ddat_i,
    output logic           dack_o,
    output logic [DW-1:0]  ddat_o,
    output logic           derr_o,
    output logic [AW-1:0]  madr_o,
    output logic           mstb_o,
    output logic           mwe_o,
    output logic [1:0]     msiz_o,
    output logic [DW-1:0]  mdat_o,
    input  logic [DW-1:0]  mdat_i,
    input  logic           mack_i
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } state_t;

    state_t state;
    logic   last_d;
    logic   gnt_i;
    logic   gnt_d;
    logic   sel_stb;
    logic   timeout;

    assign gnt_i   = (state == GNT_I);
    assign gnt_d   = (state == GNT_D);
    assign sel_stb = (gnt_i & istb_i) | (gnt_d & dstb_i);

`ifdef POLARIS_ARB_TIMEOUT_EN
    // Cycles spent in the current grant without an ack; cleared whenever idle.
    logic [15:0] cnt;

    always_ff @(posedge clk_i) begin
        if (reset_i || state == IDLE) begin
            cnt <= '0;
        end else if (!mack_i) begin
            cnt <= cnt + 16'd1;
        end
    end

    assign timeout = sel_stb && !mack_i && (cnt == 16'(TO_CYC - 1));
`else
    logic unused_to_cyc;
    assign unused_to_cyc = ^TO_CYC;
    assign timeout       = 1'b0;
`endif

    // Grant FSM: one transfer per grant, always back through IDLE.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state  <= IDLE;
            last_d <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (istb_i && (!dstb_i || last_d)) begin
                        state <= GNT_I;
                    end else if (dstb_i) begin
                        state <= GNT_D;
                    end
                end
                GNT_I: begin
                    if (!istb_i || mack_i || timeout) begin
                        state <= IDLE;
                    end
                    if (istb_i && mack_i) begin
                        last_d <= 1'b0;
                    end
                end
                GNT_D: begin
                    if (!dstb_i || mack_i || timeout) begin
                        state <= IDLE;
                    end
                    if (dstb_i && mack_i) begin
                        last_d <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Memory-side mux; everything is zero while idle.
    assign mstb_o = sel_stb;
    assign madr_o = gnt_i ? iadr_i : (gnt_d ? dadr_i : '0);
    assign mwe_o  = gnt_d & dwe_i;
    assign msiz_o = gnt_i ? 2'd2 : (gnt_d ? dsiz_i : 2'd0);
    assign mdat_o = gnt_d ? ddat_i : '0;

    // Requester side: ack only to the granted port, and only while it still strobes.
    assign iack_o = gnt_i & istb_i & mack_i;
    assign dack_o = gnt_d & dstb_i & mack_i;
    assign ierr_o = gnt_i & timeout;
    assign derr_o = gnt_d & timeout;
    assign idat_o = mdat_i[IDW-1:0];
    assign ddat_o = mdat_i;

endmodule

// File: tb/tb_polaris_bus_arbiter.sv
// Self-checking bench for polaris_bus_arbiter: directed scenarios plus random traffic against a transfer-level model.
module tb_polaris_bus_arbiter;

    localparam int unsigned AW  = 64;
    localparam int unsigned IDW = 32;
    localparam int unsigned DW  = 64;
    localparam int unsigned TO  = 4;

    logic           clk_i = 1'b0;
    logic           reset_i = 1'b1;
    logic [AW-1:0]  iadr_i = '0;
    logic           istb_i = 1'b0;
    logic           iack_o;
    logic [IDW-1:0] idat_o;
    logic           ierr_o;
    logic [AW-1:0]  dadr_i = '0;
    logic           dstb_i = 1'b0;
    logic           dwe_i = 1'b0;
    logic [1:0]     dsiz_i = 2'd0;
    logic [DW-1:0]  ddat_i = '0;
    logic           dack_o;
    logic [DW-1:0]  ddat_o;
    logic           derr_o;
    logic [AW-1:0]  madr_o;
    logic           mstb_o;
    logic           mwe_o;
    logic [1:0]     msiz_o;
    logic [DW-1:0]  mdat_o;
    logic [DW-1:0]  mdat_i = '0;
    logic           mack_i = 1'b0;

    always #5 clk_i = ~clk_i;

    polaris_bus_arbiter #(.AW(AW), .IDW(IDW), .DW(DW), .TO_CYC(TO)) dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .iadr_i(iadr_i), .istb_i(istb_i), .iack_o(iack_o), .idat_o(idat_o), .ierr_o(ierr_o),
        .dadr_i(dadr_i), .dstb_i(dstb_i), .dwe_i(dwe_i), .dsiz_i(dsiz_i), .ddat_i(ddat_i),
        .dack_o(dack_o), .ddat_o(ddat_o), .derr_o(derr_o),
        .madr_o(madr_o), .mstb_o(mstb_o), .mwe_o(mwe_o), .msiz_o(msiz_o), .mdat_o(mdat_o),
        .mdat_i(mdat_i), .mack_i(mack_i)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Transfer-level model: who owns the bus (0 none, 1 fetch, 2 data), who won last, wait cycles.
    int owner      = 0;
    bit last_was_d = 1'b1;
    int wcnt       = 0;
    bit e_iack, e_dack, e_ierr, e_derr;

    function automatic bit owner_stb();
        return (owner == 1) ? istb_i : ((owner == 2) ? dstb_i : 1'b0);
    endfunction

    function automatic bit model_timeout();
`ifdef POLARIS_ARB_TIMEOUT_EN
        return (owner != 0) && owner_stb() && !mack_i && (wcnt == int'(TO) - 1);
`else
        return 1'b0;
`endif
    endfunction

    // Let combinational outputs settle mid-cycle and compare every output against the model.
    task automatic settle();
        bit to;
        #3;
        to     = model_timeout();
        e_iack = (owner == 1) && istb_i && mack_i;
        e_dack = (owner == 2) && dstb_i && mack_i;
        e_ierr = (owner == 1) && to;
        e_derr = (owner == 2) && to;
        check("mstb", 64'(mstb_o), 64'(owner_stb()));
        check("madr", madr_o, (owner == 1) ? iadr_i : ((owner == 2) ? dadr_i : 64'd0));
        check("mwe", 64'(mwe_o), 64'((owner == 2) && dwe_i));
        check("msiz", 64'(msiz_o), (owner == 1) ? 64'd2 : ((owner == 2) ? 64'(dsiz_i) : 64'd0));
        check("mdat", mdat_o, (owner == 2) ? ddat_i : 64'd0);
        check("iack", 64'(iack_o), 64'(e_iack));
        check("dack", 64'(dack_o), 64'(e_dack));
        check("ierr", 64'(ierr_o), 64'(e_ierr));
        check("derr", 64'(derr_o), 64'(e_derr));
        if (e_iack) check("idat", 64'(idat_o), 64'(mdat_i[31:0]));
        if (e_dack) check("ddat", ddat_o, mdat_i);
    endtask

    // Clock edge: update the model from the inputs that were sampled.
    task automatic advance();
        bit stb;
        bit to;
        @(posedge clk_i);
        stb = owner_stb();
        to  = model_timeout();
        if (reset_i) begin
            owner = 0; last_was_d = 1'b1; wcnt = 0;
        end else if (owner == 0) begin
            wcnt = 0;
            if (istb_i && dstb_i) owner = last_was_d ? 2'd1 : 2'd2;
            else if (istb_i)      owner = 1;
            else if (dstb_i)      owner = 2;
        end else if (stb && mack_i) begin
            last_was_d = (owner == 2);
            owner = 0;
        end else if (!stb || to) begin
            owner = 0;
        end else begin
            wcnt++;
        end
        #1;
    endtask

    task automatic tick();
        settle();
        advance();
    endtask

    task automatic do_reset();
        istb_i = 1'b0; dstb_i = 1'b0; mack_i = 1'b0; reset_i = 1'b1;
        repeat (3) advance();
        reset_i = 1'b0;
    endtask

    bit i_pend, d_pend;
    int n_i, n_d, first_ack;

    initial begin
        #1;
        // Reset, then a single fetch.
        do_reset();
        settle();
        check("rst_mstb", 64'(mstb_o), 64'd0);
        check("rst_acks", 64'({iack_o, dack_o, ierr_o, derr_o}), 64'd0);
        advance();
        istb_i = 1'b1; iadr_i = 64'h10; mdat_i = 64'hDEAD_BEEF_0000_0013;
        tick();
        mack_i = 1'b1;
        settle();
        check("fetch_mstb", 64'(mstb_o), 64'd1);
        check("fetch_madr", madr_o, 64'h10);
        check("fetch_iack", 64'(iack_o), 64'd1);
        check("fetch_idat", 64'(idat_o), 64'h13);
        advance();

        // Tie after reset grants fetch first, then data.
        do_reset();
        istb_i = 1'b1; dstb_i = 1'b1; iadr_i = 64'h100; dadr_i = 64'h2000;
        dwe_i = 1'b1; dsiz_i = 2'd1; ddat_i = 64'h1122_3344_5566_7788;
        tick();
        mack_i = 1'b1;
        settle();
        check("tie_first_madr", madr_o, 64'h100);
        check("tie_first_iack", 64'(iack_o), 64'd1);
        advance();
        mack_i = 1'b0; istb_i = 1'b0;
        tick();
        settle();
        check("tie_d_madr", madr_o, 64'h2000);
        check("tie_d_mwe", 64'(mwe_o), 64'd1);
        check("tie_d_msiz", 64'(msiz_o), 64'd1);
        check("tie_d_mdat", mdat_o, 64'h1122_3344_5566_7788);
        advance();

        // Continuous requests with instant acks alternate I,D,I,D.
        do_reset();
        istb_i = 1'b1; dstb_i = 1'b1; mack_i = 1'b1;
        n_i = 0; n_d = 0; first_ack = 0;
        for (int c = 0; c < 16; c++) begin
            settle();
            if (iack_o) begin n_i++; if (first_ack == 0) first_ack = 1; end
            if (dack_o) begin n_d++; if (first_ack == 0) first_ack = 2; end
            advance();
        end
        check("alt_first", 64'(first_ack), 64'd1);
        check("alt_iacks", 64'(n_i), 64'd4);
        check("alt_dacks", 64'(n_d), 64'd4);

        // Data requester drops its strobe mid-grant.
        do_reset();
        dstb_i = 1'b1;
        tick();
        tick();
        dstb_i = 1'b0;
        settle();
        check("drop_mstb", 64'(mstb_o), 64'd0);
        check("drop_dack", 64'(dack_o), 64'd0);
        advance();
        tick();

        // Reset pulse mid-grant restores fetch priority on the next tie.
        do_reset();
        istb_i = 1'b1; iadr_i = 64'h40;
        tick();
        mack_i = 1'b1;
        tick();
        mack_i = 1'b0;
        tick();
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0; dstb_i = 1'b1; dadr_i = 64'h80;
        settle();
        check("rstpulse_idle", 64'(mstb_o), 64'd0);
        advance();
        settle();
        check("rstpulse_tie_madr", madr_o, 64'h40);
        check("rstpulse_tie_msiz", 64'(msiz_o), 64'd2);
        advance();

        // Data grant that never sees mack_i.
        do_reset();
        dstb_i = 1'b1; dadr_i = 64'h300;
        tick();
`ifdef POLARIS_ARB_TIMEOUT_EN
        for (int c = 1; c <= int'(TO); c++) begin
            settle();
            check("wd_derr", 64'(derr_o), 64'(c == int'(TO)));
            advance();
        end
        settle();
        check("wd_idle", 64'(mstb_o), 64'd0);
        advance();
`else
        n_d = 0;
        for (int c = 0; c < 100; c++) begin
            settle();
            if (mstb_o && !derr_o) n_d++;
            advance();
        end
        check("nowd_held", 64'(n_d), 64'd100);
`endif

        // Random traffic against the model.
        do_reset();
        i_pend = 1'b0; d_pend = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (i_pend && $urandom_range(19) == 0) begin
                i_pend = 1'b0;
            end else if (!i_pend && $urandom_range(2) == 0) begin
                i_pend = 1'b1;
                iadr_i = {$urandom, $urandom};
            end
            if (d_pend && $urandom_range(19) == 0) begin
                d_pend = 1'b0;
            end else if (!d_pend && $urandom_range(2) == 0) begin
                d_pend = 1'b1;
                dadr_i = {$urandom, $urandom};
                ddat_i = {$urandom, $urandom};
                dwe_i  = 1'($urandom_range(1));
                dsiz_i = 2'($urandom_range(3));
            end
            istb_i  = i_pend;
            dstb_i  = d_pend;
            mack_i  = 1'($urandom_range(1));
            mdat_i  = {$urandom, $urandom};
            reset_i = ($urandom_range(59) == 0);
            settle();
            advance();
            if (e_iack || e_ierr) i_pend = 1'b0;
            if (e_dack || e_derr) d_pend = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
